// File: rtl/reg_writeback_if.sv
// Writeback bus: load and ALU result channels plus the register-file write port.
interface reg_writeback_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        wb_stall;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    modport master (
        output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, wb_stall,
        input  ld_ready, alu_ready, wb_we, wb_addr, wb_data
    );

    modport slave (
        input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, wb_stall,
        output ld_ready, alu_ready, wb_we, wb_addr, wb_data
    );
endinterface

// File: rtl/reg_writeback.sv
// Register writeback: 4-entry in-order FIFO feeding one registered write-port stage.
// Define WB_BYPASS_EN to enable forwarding from queued/in-flight writes to rs1/rs2.
module reg_writeback (
    input  logic           clk,
    input  logic           reset,
    reg_writeback_if.slave bus,
    output logic [31:0]    pending,
    output logic [2:0]     occupancy,
    input  logic [4:0]     rs1_addr,
    input  logic [4:0]     rs2_addr,
    output logic           fwd1_hit,
    output logic [31:0]    fwd1_data,
    output logic           fwd2_hit,
    output logic [31:0]    fwd2_data
);
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t     mem [DEPTH];
    logic [1:0] head;
    logic [1:0] tail;
    logic [2:0] count;

    logic   ld_fire;
    logic   alu_fire;
    logic   enq;
    logic   deq;
    entry_t enq_entry;

    // Space is judged on pre-edge count, so a full FIFO never accepts even while draining.
    assign bus.ld_ready  = !reset && (count < 3'd4);
    assign bus.alu_ready = !reset && (count < 3'd4) && !bus.ld_valid;
    assign ld_fire       = bus.ld_valid && bus.ld_ready;
    assign alu_fire      = bus.alu_valid && bus.alu_ready;
    assign enq           = ld_fire || alu_fire;
    assign deq           = (count != 3'd0) && (!bus.wb_we || !bus.wb_stall);
    assign occupancy     = count;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        enq_entry = '{rd: bus.alu_rd, data: bus.alu_data};
        if (ld_fire) begin
            enq_entry = '{rd: bus.ld_rd, data: bus.ld_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 2'd1;
            if (deq) head <= head + 2'd1;
            count <= count + {2'b00, enq} - {2'b00, deq};
        end
    end

    // NOTE: storage is not reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail] <= enq_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wb_we   <= 1'b0;
            bus.wb_addr <= '0;
            bus.wb_data <= '0;
        end else if (deq) begin
            bus.wb_we   <= 1'b1;
            bus.wb_addr <= mem[head].rd;
            bus.wb_data <= mem[head].data;
        end else if (!bus.wb_stall) begin
            bus.wb_we <= 1'b0;
        end
    end

    // Slot age is its distance from head; an entry is live while its age is below count.
    always_comb begin
        pending = '0;
        if (bus.wb_we) pending[bus.wb_addr] = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            if (3'(a) < count) pending[mem[head + 2'(a)].rd] = 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    logic [4:0]  rs_addr  [2];
    logic        hit      [2];
    logic [31:0] hit_data [2];

    assign rs_addr[0] = rs1_addr;
    assign rs_addr[1] = rs2_addr;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            hit[p]      = 1'b0;
            hit_data[p] = '0;
            if (bus.wb_we && bus.wb_addr == rs_addr[p]) begin
                hit[p]      = 1'b1;
                hit_data[p] = bus.wb_data;
            end
            for (int a = 0; a < DEPTH; a++) begin
                if (3'(a) < count && mem[head + 2'(a)].rd == rs_addr[p]) begin
                    hit[p]      = 1'b1;
                    hit_data[p] = mem[head + 2'(a)].data;
                end
            end
            if (reset) begin
                hit[p]      = 1'b0;
                hit_data[p] = '0;
            end
        end
    end

    assign fwd1_hit  = hit[0];
    assign fwd1_data = hit_data[0];
    assign fwd2_hit  = hit[1];
    assign fwd2_data = hit_data[1];
`else
    wire unused_rs = ^{rs1_addr, rs2_addr};

    assign fwd1_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_hit  = 1'b0;
    assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios then randomized traffic
// compared each cycle against a queue-based model of pending register writes.
module tb_reg_writeback;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pending;
    logic [2:0]  occupancy;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        fwd1_hit;
    logic [31:0] fwd1_data;
    logic        fwd2_hit;
    logic [31:0] fwd2_data;

    reg_writeback_if bus ();

    reg_writeback dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .pending   (pending),
        .occupancy (occupancy),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    // Model: queue of accepted-but-not-issued writes, plus the write on the port.
    wr_t         q[$];
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    int n_checks = 0;
    int n_errors = 0;

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_fwd(input logic [4:0] a, output bit hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (!BYPASS || reset) return;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].rd == a) begin
                hit = 1'b1;
                d   = q[i].data;
                return;
            end
        end
        if (m_we && m_addr == a) begin
            hit = 1'b1;
            d   = m_data;
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_pend;
        bit          h1, h2;
        logic [31:0] d1, d2;
        bit          room;
        room     = !reset && q.size() < 4;
        exp_pend = '0;
        foreach (q[i]) exp_pend[q[i].rd] = 1'b1;
        if (m_we) exp_pend[m_addr] = 1'b1;
        model_fwd(rs1_addr, h1, d1);
        model_fwd(rs2_addr, h2, d2);
        check("ld_ready",  bus.ld_ready, room);
        check("alu_ready", bus.alu_ready, room && !bus.ld_valid);
        check("occupancy", occupancy, q.size());
        check("pending",   pending, exp_pend);
        check("wb_we",     bus.wb_we, m_we);
        check("wb_addr",   bus.wb_addr, m_addr);
        check("wb_data",   bus.wb_data, m_data);
        check("fwd1_hit",  fwd1_hit, h1);
        check("fwd1_data", fwd1_data, d1);
        check("fwd2_hit",  fwd2_hit, h2);
        check("fwd2_data", fwd2_data, d2);
    endtask

    task automatic model_step();
        int  pre;
        wr_t e;
        if (reset) begin
            q.delete();
            m_we   = 1'b0;
            m_addr = '0;
            m_data = '0;
            return;
        end
        pre = q.size();
        if (pre > 0 && (!m_we || !bus.wb_stall)) begin
            e      = q.pop_front();
            m_we   = 1'b1;
            m_addr = e.rd;
            m_data = e.data;
        end else if (!bus.wb_stall) begin
            m_we = 1'b0;
        end
        if (pre < 4) begin
            if (bus.ld_valid)       q.push_back('{rd: bus.ld_rd, data: bus.ld_data});
            else if (bus.alu_valid) q.push_back('{rd: bus.alu_rd, data: bus.alu_data});
        end
    endtask

    // Called at a negedge with inputs already set; returns at the following negedge.
    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.ld_valid  = 1'b0;
        bus.ld_rd     = '0;
        bus.ld_data   = '0;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.wb_stall  = 1'b0;
        rs1_addr      = '0;
        rs2_addr      = '0;
    endtask

    task automatic alu_write(input logic [4:0] rd, input logic [31:0] data);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = rd;
        bus.alu_data  = data;
    endtask

    initial begin
        idle_inputs();
        reset  = 1'b1;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, held in reset: ready low, port idle.
        cycle();
        check("reset_occ", occupancy, 3'd0);
        check("reset_we", bus.wb_we, 1'b0);
        check("reset_ldr", bus.ld_ready, 1'b0);
        reset = 1'b0;

        // Single ALU write reaches the port one cycle after acceptance.
        alu_write(5'd5, 32'hDEADBEEF);
        cycle();
        bus.alu_valid = 1'b0;
        check("alu5_queued", pending[5], 1'b1);
        cycle();
        check("alu5_we", bus.wb_we, 1'b1);
        check("alu5_addr", bus.wb_addr, 32'd5);
        check("alu5_data", bus.wb_data, 32'hDEADBEEF);
        check("alu5_pending", pending[5], 1'b1);
        cycle();
        check("alu5_retired", pending[5], 1'b0);

        // Load has priority over ALU.
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd1;
        bus.ld_data  = 32'h0000_0011;
        alu_write(5'd2, 32'h0000_0022);
        #1;
        check("prio_alu_ready", bus.alu_ready, 1'b0);
        cycle();
        bus.ld_valid = 1'b0;
        cycle();
        bus.alu_valid = 1'b0;
        check("prio_first", bus.wb_addr, 32'd1);
        cycle();
        check("prio_second", bus.wb_addr, 32'd2);
        repeat (2) cycle();

        // Stalled port: five writes fill output stage plus all four FIFO slots.
        bus.wb_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            alu_write(5'(10 + i), 32'hA000_0000 + i);
            cycle();
        end
        bus.alu_valid = 1'b0;
        #1;
        check("full_occ", occupancy, 3'd4);
        check("full_ldr", bus.ld_ready, 1'b0);
        check("full_alur", bus.alu_ready, 1'b0);
        check("full_head", bus.wb_addr, 32'd10);
        bus.wb_stall = 1'b0;
        for (int i = 1; i < 5; i++) begin
            cycle();
            check("drain_order", bus.wb_data, 32'hA000_0000 + i);
        end
        repeat (2) cycle();

        // Back-to-back writes to the same register; forwarding picks the younger one.
        alu_write(5'd7, 32'd1);
        cycle();
        alu_write(5'd7, 32'd2);
        cycle();
        bus.alu_valid = 1'b0;
        rs1_addr      = 5'd7;
        #1;
        check("same_rd_hit", fwd1_hit, BYPASS);
        check("same_rd_fwd", fwd1_data, BYPASS ? 32'd2 : 32'd0);
        cycle();
        check("same_rd_last", bus.wb_data, 32'd2);
        repeat (2) cycle();

        // Queued write to r3 with forwarding probe on rs1.
        alu_write(5'd3, 32'h3333_3333);
        cycle();
        bus.alu_valid = 1'b0;
        rs1_addr      = 5'd3;
        #1;
        check("r3_hit", fwd1_hit, BYPASS);
        check("r3_fwd", fwd1_data, BYPASS ? 32'h3333_3333 : 32'd0);
        repeat (3) cycle();

        // Reset with a stalled write and three queued entries discards everything.
        bus.wb_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_write(5'(20 + i), 32'hB000_0000 + i);
            cycle();
        end
        bus.alu_valid = 1'b0;
        #1;
        check("pre_rst_occ", occupancy, 3'd3);
        check("pre_rst_we", bus.wb_we, 1'b1);
        reset = 1'b1;
        cycle();
        check("rst_we", bus.wb_we, 1'b0);
        check("rst_occ", occupancy, 3'd0);
        check("rst_pending", pending, 32'd0);
        reset        = 1'b0;
        bus.wb_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_no_write", bus.wb_we, 1'b0);
        end

        // Randomized traffic with narrow rd range to provoke hazards and forwarding.
        for (int n = 0; n < 1500; n++) begin
            reset         = ($urandom_range(0, 99) == 0);
            bus.ld_valid  = ($urandom_range(0, 99) < 35);
            bus.ld_rd     = 5'($urandom_range(0, 7));
            bus.ld_data   = $urandom;
            bus.alu_valid = ($urandom_range(0, 99) < 50);
            bus.alu_rd    = 5'($urandom_range(0, 7));
            bus.alu_data  = $urandom;
            bus.wb_stall  = ($urandom_range(0, 99) < 35);
            rs1_addr      = 5'($urandom_range(0, 8));
            rs2_addr      = 5'($urandom_range(0, 8));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Module SHALL have one clock and a synchronous, active-high reset: clk and reset; all state SHALL change only on posedge clk.
REQ-002 clk  input  1  system clock; all outputs registered or decoded from registered state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 ld_valid / ld_ready  input / output  1 / 1  load-result channel handshake.
REQ-005 ld_rd / ld_data  input  5 / 32  load destination register / load data.
REQ-006 alu_valid / alu_ready  input / output  1 / 1  ALU-result channel handshake.
REQ-007 alu_rd / alu_data  input  5 / 32  ALU destination register / ALU data.
REQ-008 wb_stall  input  1  register-file port busy; holds the current write.
REQ-009 wb_we / wb_addr / wb_data  output  1 / 5 / 32  register-file write port: write enable, write address, write data.
REQ-010 pending  output  32  bit n=1 while any queued or in-flight write targets register n.
REQ-011 occupancy  output  3  number of valid FIFO entries, 0..4.
REQ-012 rs1_addr / rs2_addr  input  5 / 5  decode read addresses; used only when bypass is enabled.
REQ-013 fwd1_hit / fwd1_data, fwd2_hit / fwd2_data  output  1 / 32 each  forwarding result for rs1 / rs2.

Function
REQ-014 Block SHALL contain a 4-entry in-order FIFO of {rd, data} followed by one output stage that drives wb_*.
REQ-015 A transfer on a channel SHALL occur on a posedge where valid and ready are both 1; at most one enqueue per cycle.
REQ-016 ld_ready SHALL equal (occupancy < 4); alu_ready SHALL equal (occupancy < 4) AND NOT ld_valid, so load has fixed priority.
REQ-017 Full check SHALL use the pre-edge occupancy; a same-cycle dequeue SHALL NOT free space for a same-cycle enqueue when the FIFO is full.
REQ-018 When the output stage is empty, or wb_we=1 and wb_stall=0, and the FIFO is non-empty, the head SHALL move to the output stage on that edge: wb_we=1, wb_addr=rd, wb_data=data.
REQ-019 When wb_we=1 and wb_stall=1, wb_* SHALL hold unchanged; when the write retires and the FIFO is empty, wb_we SHALL go 0 and wb_addr/wb_data SHALL hold their last values.
REQ-020 Latency: an entry accepted into an empty FIFO at edge k SHALL appear on wb_* after edge k+1; with no stall, one write SHALL retire per cycle.
REQ-021 Writes SHALL retire in acceptance order, including repeated writes to the same rd; the last accepted value SHALL be the last one written.
REQ-022 pending SHALL be the OR of one-hot(rd) over valid FIFO entries and the output stage while wb_we=1; it SHALL be combinational from registered state.
REQ-023 Writes to register 0 SHALL be queued and issued like any other register; there is no hardwired zero register.
REQ-024 occupancy SHALL count FIFO entries only and SHALL exclude the output stage.

Reset
REQ-025 On reset=1 at a posedge, the FIFO SHALL empty, occupancy=0, wb_we=0, wb_addr=0, wb_data=0, and pending=0.
REQ-026 Reset SHALL discard in-flight and queued writes; no write SHALL be issued on the reset edge.
REQ-027 While reset=1, ld_ready and alu_ready SHALL be 0, and fwd*_hit SHALL be 0.

Configuration
REQ-028 Macro WB_BYPASS_EN SHALL control forwarding.
REQ-029 When WB_BYPASS_EN is defined, fwdN_hit=1 iff rsN_addr matches the output stage (wb_we=1) or a valid FIFO entry.
REQ-030 When WB_BYPASS_EN is defined, fwdN_data SHALL come from the youngest match; FIFO tail is youngest, then older entries, then the output stage.
REQ-031 When WB_BYPASS_EN is not defined, fwd1_hit, fwd2_hit, fwd1_data and fwd2_data SHALL be constant 0, and the rs*_addr inputs SHALL be ignored.

Verification
REQ-032 Stimulus: after reset, one ALU write rd=5, data=0xDEADBEEF. Required: wb_we=1, wb_addr=5, wb_data=0xDEADBEEF one cycle later; pending[5]=1 until retire.
REQ-033 Stimulus: ld_valid and alu_valid both 1 (ld rd=1, alu rd=2). Required: alu_ready=0; load retires first, ALU next.
REQ-034 Stimulus: wb_stall=1 and 5 ALU writes issued. Required: 1 in output stage, 4 in FIFO; occupancy=4; ready=0; after wb_stall=0, all retire in order, one per cycle.
REQ-035 Stimulus: writes rd=7 data=1 then rd=7 data=2. Required: both issued in order; with bypass enabled, rs1_addr=7 gives fwd1_hit=1, fwd1_data=2.
REQ-036 Stimulus: reset asserted with 3 entries queued and wb_we=1. Required: next cycle wb_we=0, occupancy=0, pending=0, and no further writes.
REQ-037 Stimulus: build without WB_BYPASS_EN, queue rd=3, set rs1_addr=3. Required: fwd1_hit=0, fwd1_data=0.
